// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock divider bank.
// Holds the lock FSM state encoding, the shadow-register reset defaults and
// the clamp helpers that keep stored divide/phase/high-time values legal.
package clk_div_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  localparam int unsigned DEF_DIV   = 2;
  localparam int unsigned DEF_PHASE = 0;
  localparam int unsigned DEF_HIGH  = DEF_DIV / 2;

  // Period below 2 cannot produce a toggling clock.
  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction

  // Limit a count-domain value to the last count of a period d (d >= 2).
  function automatic int unsigned clamp_below(input int unsigned v, input int unsigned d);
    return (v >= d) ? d - 1 : v;
  endfunction

  // High time must leave at least one high and one low cycle per period.
  function automatic int unsigned clamp_duty(input int unsigned h, input int unsigned d);
    return (h == 0) ? 1 : clamp_below(h, d);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: shadow regs, period counter, registered clock
// and rising-edge pulse.
// Macro: CLK_DIV_DUTY_CFG_EN adds duty_i and a programmable high-time reg;
// otherwise the high time is floor(D/2).
// Ports: refclk/rst clock + async active-low reset; wr_en_i loads the shadow
// regs from div_i/phase_i(/duty_i); run_d_i/run_q_i are the bank's next/current
// RUN status; outclk_o/outclk_en_o are the registered channel outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
`ifdef CLK_DIV_DUTY_CFG_EN
  input  logic [DIV_W-1:0] duty_i,
`endif
  input  logic             run_d_i,
  input  logic             run_q_i,
  output logic             outclk_o,
  output logic             outclk_en_o
);

  logic [DIV_W-1:0] div_q, phase_q, high_c, cnt_q, cnt_d, div_cl;
  logic             outclk_q, outclk_en_q, outclk_d;

  assign div_cl = DIV_W'(clamp_div(32'(div_i)));

  // Shadow registers, clamped on write so stored values are always legal.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      div_q   <= DIV_W'(DEF_DIV);
      phase_q <= DIV_W'(DEF_PHASE);
    end else if (wr_en_i) begin
      div_q   <= div_cl;
      phase_q <= DIV_W'(clamp_below(32'(phase_i), 32'(div_cl)));
    end
  end

`ifdef CLK_DIV_DUTY_CFG_EN
  logic [DIV_W-1:0] duty_q;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      duty_q <= DIV_W'(DEF_HIGH);
    end else if (wr_en_i) begin
      duty_q <= DIV_W'(clamp_duty(32'(duty_i), 32'(div_cl)));
    end
  end

  assign high_c = duty_q;
`else
  // Odd periods get the shorter half high.
  assign high_c = div_q >> 1;
`endif

  // Counter sits at the phase preload until the cycle RUN is entered, then wraps 0..D-1.
  always_comb begin
    cnt_d = phase_q;
    if (run_q_i && run_d_i) begin
      cnt_d = (cnt_q == div_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
    end
    outclk_d = run_d_i && (cnt_d < high_c);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= DIV_W'(DEF_PHASE);
      outclk_q    <= 1'b0;
      outclk_en_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      outclk_q    <= outclk_d;
      outclk_en_q <= outclk_d && !outclk_q;
    end
  end

  assign outclk_o    = outclk_q;
  assign outclk_en_o = outclk_en_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable divided clocks from one refclk, with a lock
// FSM that holds all channels during a settle window after every config.
// Macro: CLK_DIV_DUTY_CFG_EN adds the cfg_duty port (programmable high time).
// Ports: refclk clock, rst async active-low reset; cfg_valid/cfg_ready
// handshake carrying cfg_ch/cfg_div/cfg_phase(/cfg_duty); outclk, outclk_en
// and locked are registered outputs.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned LOCK_CYCLES = 16,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
`ifdef CLK_DIV_DUTY_CFG_EN
  input  logic [DIV_W-1:0]  cfg_duty,
`endif
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked
);

  localparam int unsigned LC_W = $clog2(LOCK_CYCLES + 1);

  state_e          state_q, state_d;
  logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            locked_q, cfg_ready_q, accept;

  assign accept = cfg_valid && cfg_ready_q;

  // Lock FSM: any accepted config restarts the settle window.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (accept) begin
      state_d    = WARMUP;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        WARMUP: begin
          if (lock_cnt_q == LC_W'(LOCK_CYCLES - 1)) begin
            state_d = RUN;
          end else begin
            lock_cnt_d = lock_cnt_q + LC_W'(1);
          end
        end
        RUN:     state_d = RUN;
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q     <= WARMUP;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= (state_d == RUN);
      cfg_ready_q <= 1'b1;
    end
  end

  assign locked    = locked_q;
  assign cfg_ready = cfg_ready_q;

  // Out-of-range channel numbers match no instance, so nothing is written.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .refclk     (refclk),
      .rst        (rst),
      .wr_en_i    (accept && (32'(cfg_ch) == 32'(i))),
      .div_i      (cfg_div),
      .phase_i    (cfg_phase),
`ifdef CLK_DIV_DUTY_CFG_EN
      .duty_i     (cfg_duty),
`endif
      .run_d_i    (state_d == RUN),
      .run_q_i    (state_q == RUN),
      .outclk_o   (outclk[i]),
      .outclk_en_o(outclk_en[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank against an arithmetic reference model:
// outclk[i] = locked && ((P + cycles_in_run) mod D) < H.
module tb_clk_div_bank;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned LOCK   = 16;
  localparam int unsigned CH_W   = 2;

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div, cfg_phase, cfg_duty;
  logic [NUM_CH-1:0] outclk, outclk_en;
  logic              locked;

  clk_div_bank #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
`ifdef CLK_DIV_DUTY_CFG_EN
    .cfg_duty (cfg_duty),
`endif
    .outclk   (outclk),
    .outclk_en(outclk_en),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_div[NUM_CH], m_ph[NUM_CH], m_hi[NUM_CH];
  int w;                       // edges since last restart (reset release or accept)
  bit rdy_m;
  bit [NUM_CH-1:0] prev_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    w = 0;
    rdy_m = 1'b0;
    prev_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i] = 2; m_ph[i] = 0; m_hi[i] = 1;
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare at negedge.
  task automatic cycle(input bit v, input int ch, input int d, input int p, input int h);
    bit [NUM_CH-1:0] exp_out, exp_en;
    bit lk;
    int dd;
    cfg_valid = v;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(d);
    cfg_phase = DIV_W'(p);
    cfg_duty  = DIV_W'(h);
    @(posedge refclk);
    if (v && rdy_m) begin
      if (ch < NUM_CH) begin
        dd = (d < 2) ? 2 : d;
        m_div[ch] = dd;
        m_ph[ch]  = (p >= dd) ? dd - 1 : p;
`ifdef CLK_DIV_DUTY_CFG_EN
        m_hi[ch]  = (h == 0) ? 1 : ((h >= dd) ? dd - 1 : h);
`else
        m_hi[ch]  = dd / 2;
`endif
      end
      w = 0;
    end else begin
      w++;
    end
    rdy_m = 1'b1;
    lk = (w >= LOCK);
    for (int i = 0; i < NUM_CH; i++) begin
      exp_out[i] = lk && (((m_ph[i] + w - LOCK) % m_div[i]) < m_hi[i]);
      exp_en[i]  = exp_out[i] && !prev_out[i];
    end
    prev_out = exp_out;
    @(negedge refclk);
    check("cfg_ready", 32'(cfg_ready), 32'(rdy_m));
    check("locked",    32'(locked),    32'(lk));
    check("outclk",    32'(outclk),    32'(exp_out));
    check("outclk_en", 32'(outclk_en), 32'(exp_en));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"},  32'(cfg_ready), 32'd0);
    check({tag, "_locked"}, 32'(locked),    32'd0);
    check({tag, "_outclk"}, 32'(outclk),    32'd0);
    check({tag, "_en"},     32'(outclk_en), 32'd0);
  endtask

  // Asynchronous reset pulse placed away from clock edges.
  task automatic pulse_reset();
    cfg_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge refclk);
    @(posedge refclk);
    @(negedge refclk);
    check_zero("held_rst");
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_phase = '0; cfg_duty = '0;
    model_reset();
    repeat (2) @(negedge refclk);
    check_zero("reset");
    rst = 1'b1;

    // Defaults: period 2, all channels in phase
    idle(40);
    // ch1 D=4 P=1
    cycle(1'b1, 1, 4, 1, 2);
    idle(40);
    // D=0 clamps to 2; D=7 P=9 clamps P to 6
    cycle(1'b1, 0, 0, 0, 1);
    cycle(1'b1, 1, 7, 9, 3);
    idle(60);
    // Second accept 5 cycles into WARMUP restarts the settle window
    cycle(1'b1, 2, 5, 2, 2);
    idle(5);
    cycle(1'b1, 0, 3, 0, 1);
    idle(40);
    // Mid-RUN reset restores defaults; out-of-range channel writes nothing
    pulse_reset();
    idle(20);
    cycle(1'b1, 3, 9, 4, 4);
    idle(40);
`ifdef CLK_DIV_DUTY_CFG_EN
    cycle(1'b1, 0, 5, 0, 4);
    idle(30);
    cycle(1'b1, 1, 5, 0, 9);
    idle(30);
    cycle(1'b1, 2, 5, 0, 0);
    idle(30);
`endif
    // Randomized configs with occasional mid-run resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else if ($urandom_range(0, 29) == 0) begin
        cycle(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end else begin
        cycle(1'b0, 0, 0, 0, 0);
      end
    end
    idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
